fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch unit for the 8-bit CPU. It issues byte reads to instruction memory with at most one request outstanding, and holds returned instructions with their PCs in a 2-entry buffer. It presents them to the decode/control stage over a valid/ready handshake, and it accepts PC redirects from the branch/jump path, dropping stale fetches.

## Interface
Parameters:
- `ADDR_W`, 8, instruction memory address width; the PC wraps modulo 2^ADDR_W.
- `RESET_PC`, 8'h00, first fetch address after reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request; memory accepts it in the same cycle.
- `imem_addr`  out  ADDR_W  read address; valid while `imem_req`.
- `imem_rvalid`  in  1  read data valid; at least 1 cycle after the accepted request.
- `imem_rdata`  in  8  instruction byte.
- `inst_valid`  out  1  buffer head holds a valid instruction.
- `inst_ready`  in  1  decode consumes the head when `inst_valid & inst_ready`.
- `inst`  out  8  head instruction.
- `inst_opcode`  out  5  `inst[7:3]`; drives the control decoder.
- `inst_pc`  out  ADDR_W  address the head instruction was fetched from.
- `redirect_en`  in  1  one-cycle pulse requesting a PC change (jmp, taken branch).
- `redirect_pc`  in  ADDR_W  new fetch address.

## Operation
- State:
  - `fetch_pc`
  - buffer: 2 entries of {pc, inst}, plus a count
  - FSM: IDLE (nothing outstanding), WAIT (one outstanding, keep the response), DROP (one outstanding, discard the response)
- Request rule: `imem_req = (state==IDLE) & ~redirect_en & (count < 2)`.
  - `imem_addr = fetch_pc`.
  - On a request: `fetch_pc <= fetch_pc + 1` (8'hFF wraps to 8'h00), state -> WAIT.
  - A request is issued only when a free slot is reserved for its response. Count 1 plus an outstanding request counts as full for issue purposes.
- Response: `imem_rvalid` in WAIT pushes {request pc, `imem_rdata`} at the tail, state -> IDLE. `imem_rvalid` in DROP is discarded, state -> IDLE. `imem_rvalid` in IDLE is a protocol error and is ignored.
- Pop: `inst_valid & inst_ready` removes the head. Push and pop in the same cycle leave the count unchanged.
- Redirect: `redirect_en` has priority over every other event in its cycle.
  - Buffer is flushed (count <= 0); any same-cycle pop or push is void.
  - `fetch_pc <= redirect_pc`; no request is issued in the redirect cycle.
  - WAIT/DROP with no same-cycle `imem_rvalid` -> DROP. With same-cycle `imem_rvalid` -> IDLE, response dropped.
  - IDLE -> IDLE; the first fetch of `redirect_pc` is issued the next cycle.
- Back-to-back redirects: the last one wins. Each redirect applies the rules above.

## Timing
- Reset values (asynchronous, during `rst`):
  - `fetch_pc = RESET_PC`, state IDLE, count 0
  - `imem_req = 0`, `inst_valid = 0`, `inst = 0`, `inst_opcode = 0`, `inst_pc = 0`
  - `imem_req` is gated by `rst` and rises in the first cycle after deassertion, with `imem_addr = RESET_PC`.
- Reset mid-request: the outstanding response is forgotten. A late `imem_rvalid` arrives in IDLE and is ignored.
- Latency with 1-cycle memory:
  - request in cycle N, `imem_rvalid` in N+1, `inst_valid` in N+2 (buffer output is registered)
  - steady-state throughput: 1 instruction per 2 cycles
- Redirect in cycle R with 1-cycle memory: request to `redirect_pc` in R+1, `inst_valid` with `inst_pc = redirect_pc` in R+3.
- `inst`, `inst_opcode` and `inst_pc` hold stable while `inst_valid & ~inst_ready`.

## Structure
- `param.vh` gains:
  - `IMEM_ADDR_W`, `INST_W` (8), `RESET_PC`
  - opcode field position macros (`INST_OPCODE_MSB` = 7, `INST_OPCODE_LSB` = 3)
  - FSM state encodings `FETCH_IDLE`, `FETCH_WAIT`, `FETCH_DROP`
- Sub-module `fetch_buffer`: 2-entry FIFO of {pc, inst} with push, pop, flush, count and head outputs. The FSM, PC and request logic stay in `fetch_unit`.

## Test plan
- Reset release, 1-cycle memory returning 8'h11, 8'h22, 8'h33 at addresses 0, 1, 2; `inst_ready = 1` -> `imem_req` in cycles 1, 3, 5. `inst` = 8'h11, 8'h22, 8'h33 with `inst_pc` 0, 1, 2, valid in cycles 3, 5, 7. `inst_opcode = inst[7:3]`.
- `inst_ready = 0` -> exactly 2 instructions (pc 0, 1) buffered and no further `imem_req`. Raise `inst_ready` -> fetch of pc 2 resumes the cycle after the first pop.
- Redirect to 8'h40 while a 3-cycle-latency request to pc 5 is outstanding -> the response for pc 5 is dropped and the buffer is flushed. The next `imem_req` has address 8'h40, and the next `inst_pc` is 8'h40.
- `redirect_en` in the same cycle as `imem_rvalid` and a pop -> response dropped, count 0, no request that cycle, request to `redirect_pc` the following cycle.
- Redirect to 8'hFE, run 4 fetches -> `imem_addr` sequence 8'hFE, 8'hFF, 8'h00, 8'h01.
- Assert `rst` while WAIT, deliver `imem_rvalid` during and after reset -> no push. After release: `inst_valid = 0`, then `imem_addr = RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch path.
// Imported by fetch_unit and fetch_buffer.
package fetch_unit_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int INST_W = 8;
  localparam logic [IMEM_ADDR_W-1:0] FETCH_RESET_PC = 8'h00;

  localparam int INST_OPCODE_MSB = 7;
  localparam int INST_OPCODE_LSB = 3;
  localparam int OPCODE_W = INST_OPCODE_MSB - INST_OPCODE_LSB + 1;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(
    input logic [INST_W-1:0] i
  );
    return i[INST_OPCODE_MSB:INST_OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, inst}; entry 0 is always the head.
// Flush wins over push and pop in the same cycle.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [INST_W-1:0] push_inst_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [1:0]        count_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [INST_W-1:0] head_inst_o
);

  logic [ADDR_W-1:0] pc_q [2];
  logic [INST_W-1:0] inst_q [2];
  logic [1:0]        count_q;

  logic       do_pop;
  logic       do_push;
  logic [1:0] after_pop;

  assign do_pop    = pop_i & (count_q != 2'd0);
  assign do_push   = push_i & ((count_q != 2'd2) | do_pop);
  assign after_pop = count_q - {1'b0, do_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 2'd0;
      pc_q[0]   <= '0;
      pc_q[1]   <= '0;
      inst_q[0] <= '0;
      inst_q[1] <= '0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else begin
      if (do_pop) begin
        pc_q[0]   <= pc_q[1];
        inst_q[0] <= inst_q[1];
      end
      // Write slot is the first free one once the pop has shifted.
      if (do_push) begin
        pc_q[after_pop[0]]   <= push_pc_i;
        inst_q[after_pop[0]] <= push_inst_i;
      end
      count_q <= after_pop + {1'b0, do_push};
    end
  end

  assign count_o     = count_q;
  assign head_pc_o   = pc_q[0];
  assign head_inst_o = inst_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding byte read, 2-entry instruction buffer,
// redirect flushes the buffer and discards any in-flight response.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = IMEM_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [4:0]        inst_opcode,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q;

  logic [1:0]        count;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;
  logic              push;
  logic              pop;

  // Issuing only from IDLE with count < 2 reserves a slot for the reply.
  assign imem_req  = ~rst & (state_q == FETCH_IDLE)
                   & ~redirect_en & ~count[1];
  assign imem_addr = fetch_pc_q;

  assign push = (state_q == FETCH_WAIT) & imem_rvalid;
  assign pop  = inst_valid & inst_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_en) fetch_pc_d = redirect_pc;
    else if (imem_req) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if (imem_req) req_pc_q <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_IDLE;
    end else if (redirect_en) begin
      state_q <= (state_q != FETCH_IDLE && !imem_rvalid)
               ? FETCH_DROP : FETCH_IDLE;
    end else begin
      unique case (state_q)
        FETCH_IDLE: if (imem_req) state_q <= FETCH_WAIT;
        FETCH_WAIT,
        FETCH_DROP: if (imem_rvalid) state_q <= FETCH_IDLE;
        default:    state_q <= FETCH_IDLE;
      endcase
    end
  end

  fetch_buffer #(.ADDR_W(ADDR_W)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_pc_i   (req_pc_q),
    .push_inst_i (imem_rdata),
    .pop_i       (pop),
    .flush_i     (redirect_en),
    .count_o     (count),
    .head_pc_o   (head_pc),
    .head_inst_o (head_inst)
  );

  assign inst_valid  = (count != 2'd0);
  assign inst        = inst_valid ? head_inst : '0;
  assign inst_pc     = inst_valid ? head_pc : '0;
  assign inst_opcode = opcode_of(inst);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with variable latency,
// expected stream = consecutive PCs from reset/last redirect.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_rvalid = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       inst_valid;
  logic       inst_ready = 1'b0;
  logic [7:0] inst;
  logic [4:0] inst_opcode;
  logic [7:0] inst_pc;
  logic       redirect_en = 1'b0;
  logic [7:0] redirect_pc = 8'h00;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_opcode (inst_opcode),
    .inst_pc     (inst_pc),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [256];

  typedef struct {
    logic [7:0] pc;
    logic [7:0] ins;
  } exp_t;

  exp_t       exp_q [$];
  exp_t       e;
  logic [7:0] fetch_exp;
  bit         pend;
  logic [7:0] pend_addr;
  int         wait_left;
  bit         rv_n;
  logic [7:0] rd_n;
  bit         mem_off = 1'b0;
  int         lat_min = 1;
  int         lat_max = 1;
  bit         hold_v;
  logic [7:0] hold_inst;
  logic [7:0] hold_pc;
  int         pops = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard and memory model, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      fetch_exp = FETCH_RESET_PC;
      pend      = 1'b0;
      rv_n      = 1'b0;
      hold_v    = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", inst_valid, 1);
        chk("hold_inst", inst, hold_inst);
        chk("hold_pc", inst_pc, hold_pc);
      end
      if (imem_rvalid) pend = 1'b0;
      if (redirect_en) begin
        chk("req_in_redirect", imem_req, 0);
        exp_q.delete();
        fetch_exp = redirect_pc;
      end else begin
        if (imem_req) begin
          chk("one_outstanding", pend, 0);
          chk("req_addr", imem_addr, fetch_exp);
          chk("slot_reserved", exp_q.size() < 2, 1);
          exp_q.push_back('{fetch_exp, mem[fetch_exp]});
          fetch_exp++;
          pend      = 1'b1;
          pend_addr = imem_addr;
          wait_left = $urandom_range(lat_max, lat_min);
        end
        if (inst_valid && inst_ready) begin
          chk("pop_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pop_pc", inst_pc, e.pc);
            chk("pop_inst", inst, e.ins);
            chk("pop_opcode", inst_opcode, e.ins[7:3]);
            pops++;
          end
        end
      end
      hold_v    = inst_valid && !inst_ready && !redirect_en;
      hold_inst = inst;
      hold_pc   = inst_pc;
      rv_n      = 1'b0;
      if (pend) begin
        rv_n = (wait_left == 1);
        rd_n = mem[pend_addr];
        wait_left--;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!mem_off) begin
      imem_rvalid = rv_n;
      imem_rdata  = rd_n;
    end
  end

  task automatic do_reset();
    redirect_en = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_valid"}, inst_valid, 0);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_opcode"}, inst_opcode, 0);
    chk({tag, "_pc"}, inst_pc, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1_dat [3];
    logic [7:0] t5_adr [4];
    int  nreq;
    int  got;
    bit  found;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    t1_dat[0] = 8'h11;
    t1_dat[1] = 8'h22;
    t1_dat[2] = 8'h33;

    @(negedge clk);
    chk_reset_vals("rst0");

    // T1: nominal stream, 1-cycle memory
    lat_min = 1; lat_max = 1; inst_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("t1_req_c%0d", c), imem_req, (c % 2) == 1);
      chk($sformatf("t1_valid_c%0d", c), inst_valid,
          (c >= 3) && ((c % 2) == 1));
      if (c == 3 || c == 5 || c == 7) begin
        chk($sformatf("t1_inst_c%0d", c), inst, t1_dat[(c-3)/2]);
        chk($sformatf("t1_pc_c%0d", c), inst_pc, (c-3)/2);
      end
      step();
    end

    // T2: backpressure fills exactly two entries
    inst_ready = 1'b0;
    do_reset();
    nreq = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (imem_req) nreq++;
      step();
    end
    chk("t2_nreq", nreq, 2);
    chk("t2_valid", inst_valid, 1);
    chk("t2_head_pc", inst_pc, 0);
    inst_ready = 1'b1;
    @(negedge clk);
    chk("t2_noreq_full", imem_req, 0);
    step();
    @(negedge clk);
    chk("t2_resume_req", imem_req, 1);
    chk("t2_resume_addr", imem_addr, 2);
    step();

    // T3: redirect while a 3-cycle request to pc 5 is outstanding
    lat_min = 3; lat_max = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 8'h05) found = 1'b1;
      else step();
    end
    chk("t3_found_pc5", found, 1);
    step();
    redirect_en = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    chk("t3_noreq_redirect", imem_req, 0);
    step();
    redirect_en = 1'b0;
    @(negedge clk);
    chk("t3_flushed", inst_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (i > 0) @(negedge clk);
      if (imem_req) begin
        found = 1'b1;
        chk("t3_next_addr", imem_addr, 8'h40);
      end
      step();
    end
    chk("t3_req_seen", found, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        found = 1'b1;
        chk("t3_next_pc", inst_pc, 8'h40);
      end
      step();
    end
    chk("t3_valid_seen", found, 1);

    // T4: redirect coinciding with rvalid and a pop
    lat_min = 1; lat_max = 1; inst_ready = 1'b0;
    do_reset();
    repeat (3) step();
    redirect_en = 1'b1;
    redirect_pc = 8'h80;
    inst_ready  = 1'b1;
    @(negedge clk);
    chk("t4_valid_c4", inst_valid, 1);
    chk("t4_noreq_c4", imem_req, 0);
    step();
    redirect_en = 1'b0;
    @(negedge clk);
    chk("t4_count0_c5", inst_valid, 0);
    chk("t4_req_c5", imem_req, 1);
    chk("t4_addr_c5", imem_addr, 8'h80);
    step();
    @(negedge clk);
    chk("t4_valid_c6", inst_valid, 0);
    step();
    @(negedge clk);
    chk("t4_valid_c7", inst_valid, 1);
    chk("t4_pc_c7", inst_pc, 8'h80);
    chk("t4_inst_c7", inst, mem[8'h80]);
    step();

    // T5: PC wrap
    t5_adr[0] = 8'hFE;
    t5_adr[1] = 8'hFF;
    t5_adr[2] = 8'h00;
    t5_adr[3] = 8'h01;
    redirect_en = 1'b1;
    redirect_pc = 8'hFE;
    step();
    redirect_en = 1'b0;
    got = 0;
    for (int i = 0; i < 30 && got < 4; i++) begin
      @(negedge clk);
      if (imem_req) begin
        chk($sformatf("t5_addr%0d", got), imem_addr, t5_adr[got]);
        got++;
      end
      step();
    end
    chk("t5_nfetch", got, 4);

    // Random traffic
    lat_min = 1; lat_max = 3;
    pops = 0;
    for (int i = 0; i < 1500; i++) begin
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect_en = ($urandom_range(0, 19) == 0);
      redirect_pc = 8'($urandom);
      step();
    end
    redirect_en = 1'b0;
    inst_ready  = 1'b1;
    chk("rand_progress", pops >= 100, 1);

    // T6: reset while WAIT, late responses ignored
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (imem_req) found = 1'b1;
      else step();
    end
    chk("t6_req_seen", found, 1);
    mem_off = 1'b1;
    step();
    imem_rvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("t6_rst");
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 8'hAA;
    @(negedge clk);
    chk("t6_valid_in_rst", inst_valid, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_c1", inst_valid, 0);
    chk("t6_req_c1", imem_req, 1);
    chk("t6_addr_c1", imem_addr, FETCH_RESET_PC);
    step();
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("t6_valid_c2", inst_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
